// File: rtl/rx_top_module.sv
// rtl/rx_top_module.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module rx_top_module #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rx_rst,
    input  logic       rx_en,
    input  logic       rx_bit,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    always_ff @(posedge clk) begin
        if (rx_rst) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            armed     <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx_bit;
            rx_s      <= sync1;
            done      <= 1'b0;
            frame_err <= 1'b0;

            // A low line first seen while disabled must return high before it can start a frame
            if (rx_s)
                armed <= 1'b1;
            else if (!rx_en)
                armed <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (rx_en && armed && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7)
                            state <= STOP;
                        else
                            idx <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out <= shift;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    busy <= 1'b1;
                    cnt  <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_top_module.sv
// tb/tb_rx_top_module.sv - self-checking bench for rx_top_module
module tb_rx_top_module;
    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       rx_rst;
    logic       rx_en;
    logic       rx_bit;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       frame_err;

    rx_top_module #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rx_rst(rx_rst), .rx_en(rx_en), .rx_bit(rx_bit),
        .data_out(data_out), .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit busy_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_e;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_done;
        int         exp_ferr;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial driver standing in for the transmit side; drop_en_bit indexes start=0, data=1..8, stop=9
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_ok, input int drop_en_bit);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (expect_ok) exp_q.push_back(d);
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == drop_en_bit) rx_en = 1'b0;
            rx_bit = bits[i];
            tick(C);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (frame_err) ferr_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_busy_low", busy, 0);
            check("done_ferr_excl", frame_err, 0);
            check("sb_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_data", data_out, sb_e);
            end
        end
    end

    initial begin
        tbl[0] = '{8'h29, 1'b1, 20, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 0, 2, 0};
        tbl[2] = '{8'hFF, 1'b1, 0, 3, 0};
        tbl[3] = '{8'hA5, 1'b1, 0, 4, 0};

        rx_rst = 1'b1;
        rx_en  = 1'b1;
        rx_bit = 1'b1;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_data", data_out, 8'h00);
        rx_rst = 1'b0;
        tick(5);

        // Single frame with latency, then back-to-back frames
        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, 1'b1, -1);
            check("tbl_done_cnt", done_cnt, tbl[i].exp_done);
            check("tbl_ferr_cnt", ferr_cnt, tbl[i].exp_ferr);
            check("tbl_data", data_out, tbl[i].data);
            if (i == 0) check("latency", done_cyc - start_cyc - 1, H + 9 * C + 2);
            rx_bit = 1'b1;
            tick(tbl[i].gap);
        end
        tick(20);

        // Bad stop bit followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        tick(40);
        check("ferr_busy_held", busy, 1);
        check("ferr_cnt", ferr_cnt, 1);
        check("ferr_no_done", done_cnt, 4);
        check("ferr_data_held", data_out, 8'hA5);
        rx_bit = 1'b1;
        tick(4);
        check("ferr_busy_release", busy, 0);
        tick(10);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        tick(5);
        check("after_ferr_done", done_cnt, 5);
        check("after_ferr_data", data_out, 8'h5A);

        // Short glitch: false start
        rx_bit = 1'b0;
        tick(4);
        rx_bit = 1'b1;
        tick(1);
        check("glitch_busy_high", busy, 1);
        tick(6);
        check("glitch_busy_low", busy, 0);
        tick(10);
        check("glitch_no_done", done_cnt, 5);
        check("glitch_no_ferr", ferr_cnt, 1);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        tick(5);
        check("after_glitch_data", data_out, 8'h81);

        // Reset mid-way through data bit 4
        rx_bit = 1'b0;
        tick(C);
        for (int k = 0; k < 4; k++) begin
            rx_bit = k[0];
            tick(C);
        end
        rx_bit = 1'b0;
        tick(H);
        rx_rst = 1'b1;
        rx_bit = 1'b1;
        tick(1);
        rx_rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_data", data_out, 8'h00);
        tick(30);
        check("midrst_busy_later", busy, 0);
        check("midrst_no_done", done_cnt, 6);
        check("midrst_no_ferr", ferr_cnt, 1);
        send_frame(8'hC3, 1'b1, 1'b1, -1);
        tick(5);
        check("after_rst_done", done_cnt, 7);
        check("after_rst_data", data_out, 8'hC3);

        // rx_en dropped mid-frame, then a frame while disabled
        rx_en = 1'b1;
        send_frame(8'h96, 1'b1, 1'b1, 3);
        tick(5);
        check("en_drop_done", done_cnt, 8);
        check("en_drop_data", data_out, 8'h96);
        busy_seen = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        tick(5);
        check("disabled_no_busy", busy_seen, 0);
        check("disabled_no_done", done_cnt, 8);

        // Enable rising inside an already-low bit must not start a frame
        busy_seen = 1'b0;
        rx_bit = 1'b0;
        tick(5);
        rx_en = 1'b1;
        tick(C - 5);
        rx_bit = 1'b1;
        tick(10);
        check("late_en_no_busy", busy_seen, 0);

        // Loopback-style frame with matching bit timing
        send_frame(8'h29, 1'b1, 1'b1, -1);
        tick(5);
        check("loopback_data", data_out, 8'h29);
        check("final_done_cnt", done_cnt, 9);
        check("final_ferr_cnt", ferr_cnt, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
